// File: rtl/arb_pkg.sv
// Shared types and widths for the SDRAM port arbiter.
// State encoding is visible on the debug port, so keep the enum values fixed.
package arb_pkg;

  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int NUM_REQ = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_t;

  function automatic arb_state_t own_state(input logic id);
    return id ? OWN1 : OWN0;
  endfunction

endpackage

// File: rtl/tag_fifo.sv
// Ring-buffer FIFO of requester ids, one entry per accepted-but-unreturned read.
// DEPTH must be a power of two so the pointers wrap naturally.
module tag_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_id,
  input  logic             pop,
  output logic [WIDTH-1:0] head_id,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == DEPTH_C);
  assign empty   = (count == '0);
  assign head_id = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (!do_push && do_pop) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_id;
  end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Round-robin arbiter sharing one SDRAM Avalon-MM port between two requesters, with read-return routing.
// Handshake: a request (read|write) transfers on a cycle where its waitrequest is low; until then the requester holds it.
module sdram_port_arbiter
  import arb_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_REQ-1:0][ADDR_W-1:0]  req_address,
  input  logic [NUM_REQ-1:0]              req_read,
  input  logic [NUM_REQ-1:0]              req_write,
  input  logic [NUM_REQ-1:0][DATA_W-1:0]  req_writedata,
  output logic [NUM_REQ-1:0]              req_waitrequest,
  output logic [NUM_REQ-1:0][DATA_W-1:0]  req_readdata,
  output logic [NUM_REQ-1:0]              req_readdatavalid,
  input  logic                            master_waitrequest,
  output logic [ADDR_W-1:0]               master_address,
  output logic                            master_read,
  output logic                            master_write,
  output logic [DATA_W-1:0]               master_writedata,
  input  logic [DATA_W-1:0]               master_readdata,
  input  logic                            master_readdatavalid,
  output logic                            err_orphan_rdv,
  output arb_state_t                      dbg_state
);

  arb_state_t          state;
  arb_state_t          state_nxt;
  logic                prio;
  logic [NUM_REQ-1:0]  active;
  logic                owned;
  logic                owner_id;
  logic                rd_req;
  logic                accept;
  logic                fifo_push;
  logic                fifo_pop;
  logic                fifo_full;
  logic                fifo_empty;
  logic [0:0]          head_id;

  assign active    = req_read | req_write;
  assign owned     = (state == OWN0) || (state == OWN1);
  assign owner_id  = (state == OWN1);
  // Write wins when a requester illegally raises both strobes.
  assign rd_req    = req_read[owner_id] && !req_write[owner_id];
  assign accept    = (master_read || master_write) && !master_waitrequest;
  assign fifo_push = master_read && !master_waitrequest;
  assign fifo_pop  = master_readdatavalid && !fifo_empty;
  assign dbg_state = state;
  assign req_readdata = {NUM_REQ{master_readdata}};

  tag_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH (1)
  ) u_tag_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (fifo_push),
    .push_id (owner_id),
    .pop     (fifo_pop),
    .head_id (head_id),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      prio           <= 1'b0;
      err_orphan_rdv <= 1'b0;
    end else begin
      state <= state_nxt;
      if (owned && accept)                      prio           <= ~owner_id;
      if (master_readdatavalid && fifo_empty)   err_orphan_rdv <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (&active)        state_nxt = own_state(prio);
        else if (active[0]) state_nxt = OWN0;
        else if (active[1]) state_nxt = OWN1;
      end
      OWN0, OWN1: begin
        if (!active[owner_id]) state_nxt = IDLE;
        else if (accept)       state_nxt = active[~owner_id] ? own_state(~owner_id) : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_waitrequest   = '1;
    req_readdatavalid = '0;
    master_read       = 1'b0;
    master_write      = 1'b0;
    master_address    = '0;
    master_writedata  = '0;
    if (owned) begin
      master_address   = req_address[owner_id];
      master_writedata = req_writedata[owner_id];
      master_write     = req_write[owner_id];
      // A full tag FIFO blocks reads; a pop in this cycle does not help until next cycle.
      master_read      = rd_req && !fifo_full;
      req_waitrequest[owner_id] = master_waitrequest || (rd_req && fifo_full);
    end
    if (fifo_pop) req_readdatavalid[head_id] = 1'b1;
  end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Bench for sdram_port_arbiter: queue-based reference model checked every cycle, plus directed scenarios.
module tb_sdram_port_arbiter;
  import arb_pkg::*;

  localparam int MAXO  = 4;
  localparam int TXN_N = 2048;
  localparam int LOG_N = 4096;
  localparam int LIT_N = 256;

  logic                            clk;
  logic                            rst;
  logic [NUM_REQ-1:0][ADDR_W-1:0]  req_address;
  logic [NUM_REQ-1:0]              req_read;
  logic [NUM_REQ-1:0]              req_write;
  logic [NUM_REQ-1:0][DATA_W-1:0]  req_writedata;
  logic [NUM_REQ-1:0]              req_waitrequest;
  logic [NUM_REQ-1:0][DATA_W-1:0]  req_readdata;
  logic [NUM_REQ-1:0]              req_readdatavalid;
  logic                            master_waitrequest;
  logic [ADDR_W-1:0]               master_address;
  logic                            master_read;
  logic                            master_write;
  logic [DATA_W-1:0]               master_writedata;
  logic [DATA_W-1:0]               master_readdata;
  logic                            master_readdatavalid;
  logic                            err_orphan_rdv;
  arb_state_t                      dbg_state;

  sdram_port_arbiter #(.MAX_OUTSTANDING(MAXO)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .req_address          (req_address),
    .req_read             (req_read),
    .req_write            (req_write),
    .req_writedata        (req_writedata),
    .req_waitrequest      (req_waitrequest),
    .req_readdata         (req_readdata),
    .req_readdatavalid    (req_readdatavalid),
    .master_waitrequest   (master_waitrequest),
    .master_address       (master_address),
    .master_read          (master_read),
    .master_write         (master_write),
    .master_writedata     (master_writedata),
    .master_readdata      (master_readdata),
    .master_readdatavalid (master_readdatavalid),
    .err_orphan_rdv       (err_orphan_rdv),
    .dbg_state            (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // transaction tables: main appends (tx_wr), driver consumes (tx_rd)
  logic        tx_is_wr [2][TXN_N];
  logic [31:0] tx_addr  [2][TXN_N];
  logic [31:0] tx_data  [2][TXN_N];
  int          tx_wr [2] = '{0, 0};
  int          tx_rd [2] = '{0, 0};
  bit          act   [2] = '{0, 0};
  int          mwr_force = 0;
  bit          rsp_auto  = 0;
  bit          rand_gaps = 0;
  int          rdv_req   = 0;
  int          rdv_sent  = 0;
  int          n_returned = 0;

  // literal expectations posted by main, compared by the monitor
  string       lit_nm  [LIT_N];
  logic [63:0] lit_act [LIT_N];
  logic [63:0] lit_exp [LIT_N];
  int          lit_wr = 0;
  int          lit_rd = 0;

  // monitor-owned state
  int          n_cmp = 0;
  int          n_mis = 0;
  int          cyc = 0;
  int          m_owner = -1;
  int          m_prio = 0;
  int          m_tags[$];
  bit          m_err = 0;
  logic [1:0]  acc_flag = 2'b00;
  int          glog_id  [LOG_N];
  int          glog_cyc [LOG_N];
  int          glog_n = 0;
  int          rlog_id  [LOG_N];
  logic [31:0] rlog_data[LOG_N];
  int          rlog_n = 0;
  int          n_issued = 0;

  task automatic cmp(input string nm, input logic [63:0] act_v, input logic [63:0] exp_v);
    n_cmp++;
    if (act_v !== exp_v) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act_v, exp_v, cyc);
    end
  endtask

  // scoreboard: reference model evaluated on every falling edge
  always @(negedge clk) begin : mon
    logic [1:0]  e_wait;
    logic [1:0]  e_rdv;
    logic        e_mr;
    logic        e_mw;
    logic [31:0] e_addr;
    logic [31:0] e_wd;
    logic        is_rd;
    logic        blk;
    logic        acc;
    int          k;
    cyc++;
    while (lit_rd < lit_wr) begin
      cmp(lit_nm[lit_rd], lit_act[lit_rd], lit_exp[lit_rd]);
      lit_rd++;
    end
    if (rst) begin
      m_owner = -1;
      m_prio  = 0;
      m_tags.delete();
      m_err   = 0;
    end
    e_wait = 2'b11; e_rdv = 2'b00; e_mr = 1'b0; e_mw = 1'b0; e_addr = '0; e_wd = '0;
    if (m_owner >= 0) begin
      k      = m_owner;
      is_rd  = req_read[k] && !req_write[k];
      blk    = is_rd && (m_tags.size() == MAXO);
      e_mw   = req_write[k];
      e_mr   = is_rd && !blk;
      e_addr = req_address[k];
      e_wd   = req_writedata[k];
      e_wait[k] = master_waitrequest || blk;
    end
    if (master_readdatavalid && m_tags.size() > 0) e_rdv[m_tags[0]] = 1'b1;
    cmp("waitrequest", 64'(req_waitrequest), 64'(e_wait));
    cmp("master_read", 64'(master_read), 64'(e_mr));
    cmp("master_write", 64'(master_write), 64'(e_mw));
    cmp("master_address", 64'(master_address), 64'(e_addr));
    cmp("master_writedata", 64'(master_writedata), 64'(e_wd));
    cmp("readdatavalid", 64'(req_readdatavalid), 64'(e_rdv));
    cmp("readdata0", 64'(req_readdata[0]), 64'(master_readdata));
    cmp("readdata1", 64'(req_readdata[1]), 64'(master_readdata));
    cmp("err_orphan_rdv", 64'(err_orphan_rdv), 64'(m_err));
    cmp("state", 64'(dbg_state), 64'(m_owner + 1));
    acc_flag = 2'b00;
    if (!rst) begin
      acc = (e_mr || e_mw) && !master_waitrequest;
      if (master_readdatavalid) begin
        if (m_tags.size() > 0) m_tags.delete(0);
        else m_err = 1;
      end
      if (acc && e_mr) m_tags.push_back(m_owner);
      if (m_owner < 0) begin
        if ((req_read[0] || req_write[0]) && (req_read[1] || req_write[1])) m_owner = m_prio;
        else if (req_read[0] || req_write[0]) m_owner = 0;
        else if (req_read[1] || req_write[1]) m_owner = 1;
      end else begin
        k = m_owner;
        if (!(req_read[k] || req_write[k])) m_owner = -1;
        else if (acc) begin
          m_prio  = 1 - k;
          m_owner = (req_read[1-k] || req_write[1-k]) ? 1 - k : -1;
        end
      end
      for (int kk = 0; kk < 2; kk++) begin
        acc_flag[kk] = (req_read[kk] || req_write[kk]) && !req_waitrequest[kk];
        if (acc_flag[kk] && glog_n < LOG_N) begin
          glog_id[glog_n]  = kk;
          glog_cyc[glog_n] = cyc;
          glog_n++;
        end
      end
      if (master_read && !master_waitrequest) n_issued++;
      if ((|req_readdatavalid) && rlog_n < LOG_N) begin
        rlog_id[rlog_n]   = req_readdatavalid[1] ? 1 : 0;
        rlog_data[rlog_n] = req_readdata[rlog_id[rlog_n]];
        rlog_n++;
      end
    end
  end

  // driver: requesters and SDRAM slave side, updated 1 time unit after each rising edge
  initial begin : drv
    int gap [2];
    gap = '{0, 0};
    req_address = '0; req_read = '0; req_write = '0; req_writedata = '0;
    master_waitrequest = 1'b0; master_readdata = '0; master_readdatavalid = 1'b0;
    forever begin
      @(posedge clk); #1;
      for (int k = 0; k < 2; k++) begin
        if (act[k] && acc_flag[k]) begin
          act[k] = 0; req_read[k] = 1'b0; req_write[k] = 1'b0;
        end
        if (!act[k] && tx_rd[k] < tx_wr[k]) begin
          if (gap[k] > 0) gap[k]--;
          else begin
            req_write[k]     = tx_is_wr[k][tx_rd[k]];
            req_read[k]      = !tx_is_wr[k][tx_rd[k]];
            req_address[k]   = tx_addr[k][tx_rd[k]];
            req_writedata[k] = tx_data[k][tx_rd[k]];
            tx_rd[k]++;
            act[k] = 1;
            gap[k] = rand_gaps ? int'($urandom_range(0, 3)) : 0;
          end
        end
      end
      master_waitrequest   = (mwr_force < 0) ? ($urandom_range(0, 9) < 3) : (mwr_force != 0);
      master_readdatavalid = 1'b0;
      master_readdata      = $urandom;
      if (rdv_sent < rdv_req) begin
        master_readdatavalid = 1'b1;
        master_readdata      = 32'h10 + 32'(rdv_sent);
        rdv_sent++;
        n_returned++;
      end else if (rsp_auto && n_issued > n_returned && $urandom_range(0, 2) == 0) begin
        master_readdatavalid = 1'b1;
        n_returned++;
      end
    end
  end

  task automatic post(input string nm, input logic [63:0] act_v, input logic [63:0] exp_v);
    lit_nm[lit_wr]  = nm;
    lit_act[lit_wr] = act_v;
    lit_exp[lit_wr] = exp_v;
    lit_wr++;
  endtask

  task automatic push_txn(input int k, input bit wr, input logic [31:0] a, input logic [31:0] d);
    tx_is_wr[k][tx_wr[k]] = wr;
    tx_addr[k][tx_wr[k]]  = a;
    tx_data[k][tx_wr[k]]  = d;
    tx_wr[k]++;
  endtask

  task automatic wait_grants(input int n, input int budget, input string nm);
    int i = 0;
    while (glog_n < n && i < budget) begin
      @(negedge clk); #1;
      i++;
    end
    if (glog_n < n) post(nm, 64'(glog_n), 64'(n));
  endtask

  task automatic wait_quiet(input int budget, input string nm);
    int i = 0;
    while (!(tx_rd[0] == tx_wr[0] && tx_rd[1] == tx_wr[1] && !act[0] && !act[1]
             && n_issued == n_returned) && i < budget) begin
      @(negedge clk); #1;
      i++;
    end
    if (i >= budget) post(nm, 64'(0), 64'(1));
  endtask

  task automatic reset_dut();
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin : main
    int g0;
    int r0;
    bit found;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // reset values
    @(negedge clk);
    post("rst_wait", 64'(req_waitrequest), 64'(2'b11));
    post("rst_rdwr", 64'({master_read, master_write}), 64'(0));
    post("rst_err", 64'(err_orphan_rdv), 64'(0));
    post("rst_addr", 64'(master_address), 64'(0));

    // solo write
    push_txn(0, 1'b1, 32'd6, 32'hCDDDEEEF);
    @(negedge clk);
    post("sw_idle_wait", 64'(req_waitrequest), 64'(2'b11));
    post("sw_idle_mw", 64'(master_write), 64'(0));
    @(negedge clk);
    post("sw_own0", 64'(dbg_state), 64'(OWN0));
    post("sw_mw", 64'(master_write), 64'(1));
    post("sw_addr", 64'(master_address), 64'(6));
    post("sw_data", 64'(master_writedata), 64'(32'hCDDDEEEF));
    post("sw_wait", 64'(req_waitrequest), 64'(2'b10));
    @(negedge clk);
    post("sw_mw_done", 64'(master_write), 64'(0));
    post("sw_idle_again", 64'(dbg_state), 64'(IDLE));

    // contention: alternate grants starting with requester 0
    reset_dut();
    g0 = glog_n;
    for (int i = 0; i < 3; i++) begin
      push_txn(0, 1'b1, 32'h1000 + 32'(i), 32'hA000 + 32'(i));
      push_txn(1, 1'b1, 32'h2000 + 32'(i), 32'hB000 + 32'(i));
    end
    wait_grants(g0 + 6, 40, "cont_timeout");
    for (int i = 0; i < 6; i++) begin
      post("cont_grant", 64'(glog_id[g0+i]), 64'(i % 2));
      if (i > 0) post("cont_gap", 64'(glog_cyc[g0+i] - glog_cyc[g0+i-1]), 64'(1));
    end
    wait_quiet(50, "cont_quiet");

    // pipelined reads routed back in issue order
    g0 = glog_n;
    r0 = rlog_n;
    for (int i = 0; i < 3; i++) push_txn(0, 1'b0, 32'h300 + 32'(4*i), 32'h0);
    for (int i = 0; i < 2; i++) push_txn(1, 1'b0, 32'h400 + 32'(4*i), 32'h0);
    wait_grants(g0 + 4, 40, "pipe_issue_timeout");
    rdv_req += 5;
    for (int i = 0; i < 40 && rlog_n < r0 + 5; i++) begin
      @(negedge clk); #1;
    end
    if (rlog_n < r0 + 5) post("pipe_ret_timeout", 64'(rlog_n - r0), 64'(5));
    for (int i = 0; i < 5; i++) begin
      post("pipe_grant", 64'(glog_id[g0+i]), 64'(i % 2));
      post("pipe_route", 64'(rlog_id[r0+i]), 64'(i % 2));
      post("pipe_data", 64'(rlog_data[r0+i]), 64'(32'h10 + 32'(i)));
    end
    wait_quiet(50, "pipe_quiet");

    // FIFO full: writes still pass, fifth read waits one cycle past the pop
    g0 = glog_n;
    for (int i = 0; i < MAXO; i++) push_txn(0, 1'b0, 32'h500 + 32'(4*i), 32'h0);
    wait_grants(g0 + MAXO, 60, "full_issue_timeout");
    push_txn(1, 1'b1, 32'h600, 32'h600DF00D);
    wait_grants(g0 + MAXO + 1, 20, "full_wr_timeout");
    post("full_wr_grant", 64'(glog_id[g0+MAXO]), 64'(1));
    push_txn(0, 1'b0, 32'h700, 32'h0);
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (dbg_state == OWN0 && req_read[0] && req_waitrequest[0]) found = 1;
    end
    if (!found) post("full_block_timeout", 64'(0), 64'(1));
    rdv_req += 1;
    @(negedge clk);
    post("full_stall_wait", 64'(req_waitrequest[0]), 64'(1));
    post("full_stall_mr", 64'(master_read), 64'(0));
    post("full_pop_rdv", 64'(req_readdatavalid), 64'(2'b01));
    @(negedge clk);
    post("full_acc_wait", 64'(req_waitrequest[0]), 64'(0));
    post("full_acc_mr", 64'(master_read), 64'(1));
    rdv_req += MAXO;
    wait_quiet(60, "full_quiet");

    // SDRAM stall while requester 1 owns the port
    g0 = glog_n;
    mwr_force = 1;
    push_txn(1, 1'b1, 32'h44, 32'hA5A55A5A);
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (dbg_state == OWN1) found = 1;
    end
    if (!found) post("stall_own_timeout", 64'(0), 64'(1));
    push_txn(0, 1'b1, 32'h88, 32'h12345678);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      post("stall_state", 64'(dbg_state), 64'(OWN1));
      post("stall_addr", 64'(master_address), 64'(32'h44));
      post("stall_data", 64'(master_writedata), 64'(32'hA5A55A5A));
      post("stall_wait", 64'(req_waitrequest), 64'(2'b11));
    end
    mwr_force = 0;
    wait_grants(g0 + 2, 20, "stall_release_timeout");
    post("stall_grant_a", 64'(glog_id[g0]), 64'(1));
    post("stall_grant_b", 64'(glog_id[g0+1]), 64'(0));
    wait_quiet(50, "stall_quiet");

    // randomized traffic against the reference model
    rand_gaps = 1;
    mwr_force = -1;
    rsp_auto  = 1;
    for (int i = 0; i < 250; i++) begin
      for (int k = 0; k < 2; k++) push_txn(k, 1'($urandom_range(0, 1)), $urandom, $urandom);
    end
    wait_quiet(20000, "rand_quiet");
    rand_gaps = 0;
    mwr_force = 0;
    rsp_auto  = 0;

    // reset with reads in flight, then an orphan return
    g0 = glog_n;
    push_txn(0, 1'b0, 32'h900, 32'h0);
    push_txn(0, 1'b0, 32'h904, 32'h0);
    wait_grants(g0 + 2, 20, "orph_issue_timeout");
    reset_dut();
    r0 = rlog_n;
    rdv_req += 1;
    repeat (3) @(negedge clk);
    post("orph_err", 64'(err_orphan_rdv), 64'(1));
    post("orph_no_route", 64'(rlog_n), 64'(r0));
    repeat (5) @(negedge clk);
    post("orph_sticky", 64'(err_orphan_rdv), 64'(1));
    reset_dut();
    post("orph_clear", 64'(err_orphan_rdv), 64'(0));

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
